sliding_window_sum: RTL and testbench

//  - Removal-side counterpart of the cumulative-sum datapath.
//  - Keeps a running sum over the last WIN accepted samples (box-filter column/row sum).
//  - Each accepted sample is added, and the sample accepted WIN updates earlier is subtracted.
//  - Sits after the per-column summers in the filter pipeline. Its output feeds the mean/threshold stages.

---
 rtl/sliding_sum_pkg.sv | 24 ++
 rtl/window_delay_buf.sv | 54 +++++
 rtl/sliding_window_sum.sv | 108 ++++++++++
 tb/tb_sliding_window_sum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sliding_sum_pkg.sv
// Shared defaults and helpers for the sliding-window sum block.
// Optional overflow flag is enabled by defining SLIDING_SUM_OVF_EN.
package sliding_sum_pkg;

    localparam int DEF_DATA_W = 13;
    localparam int DEF_SUM_W  = 16;
    localparam int DEF_WIN    = 5;
    localparam int DEF_PTR_W  = 4;
    localparam int WIN_MAX    = 16;

    // Ceiling log2 usable in constant expressions; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/window_delay_buf.sv
// Circular delay line of WIN samples with its own wrap-around write pointer.
// The read port shows the entry at the write pointer, i.e. the sample written
// WIN writes ago, before this cycle's write replaces it.
module window_delay_buf
    import sliding_sum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIN    = DEF_WIN,
    parameter int PTR_W  = DEF_PTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              restart,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [PTR_W-1:0]  wptr
);

    localparam int              AW      = clog2(WIN);
    localparam int              DEPTH   = 1 << AW;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WIN - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_addr;
    logic [PTR_W-1:0]  ptr_inc;

    // A restart always writes slot 0; otherwise write at the running pointer.
    assign wr_addr = restart ? '0 : wptr;
    assign ptr_inc = (wr_addr == PTR_LAST) ? '0 : wr_addr + PTR_ONE;

    // Read the oldest sample before this cycle's write lands.
    assign rdata = mem[wptr[AW-1:0]];

    // Write pointer: wraps at WIN-1, reset to slot 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wptr <= '0;
        end else if (we) begin
            wptr <= ptr_inc;
        end
    end

    // Sample storage; contents are qualified by the fill count in the parent.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are never read before being rewritten.
        if (we) begin
            mem[wr_addr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sliding_window_sum.sv
// Running sum over the last WIN accepted samples (box-filter row/column sum).
// Define SLIDING_SUM_OVF_EN to add the sticky ovf output.
module sliding_window_sum
    import sliding_sum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int WIN    = DEF_WIN,
    parameter int PTR_W  = DEF_PTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sol,
    input  logic [DATA_W-1:0] data_in,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid,
    output logic [PTR_W:0]    fill
`ifdef SLIDING_SUM_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [PTR_W:0] FILL_WIN = (PTR_W + 1)'(WIN);
    localparam logic [PTR_W:0] FILL_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] old_sample;
    logic [PTR_W-1:0]  wptr;
    logic              restart;
    logic              full;
    logic [SUM_W:0]    data_ext;
    logic [SUM_W:0]    old_ext;
    logic [SUM_W:0]    add_res;
    logic [SUM_W:0]    sum_nxt;
    logic              unused_msb;

    // An empty window (after reset) is restarted exactly like a start of line.
    assign restart  = en && (sol || (fill == '0));
    assign full     = (fill == FILL_WIN);
    assign data_ext = (SUM_W + 1)'(data_in);
    assign old_ext  = (SUM_W + 1)'(old_sample);
    assign add_res  = {1'b0, sum_out} + data_ext;

    window_delay_buf #(
        .DATA_W (DATA_W),
        .WIN    (WIN),
        .PTR_W  (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (en),
        .restart (restart),
        .wdata   (data_in),
        .rdata   (old_sample),
        .wptr    (wptr)
    );

    // Next sum for a continuing window: add new sample, drop the oldest once full.
    always_comb begin
        // NOTE: default assignment first so no path leaves sum_nxt unassigned (no latch).
        sum_nxt = add_res;
        if (full) begin
            sum_nxt = add_res - old_ext;
        end
    end

    // The carry out of the window result is not needed once truncated.
    assign unused_msb = sum_nxt[SUM_W] ^ (^wptr);

    // Sum, fill count and valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
            fill      <= '0;
        end else if (!en) begin
            sum_valid <= 1'b0;
        end else if (restart) begin
            sum_out   <= SUM_W'(data_in);
            fill      <= FILL_ONE;
            sum_valid <= (WIN == 1);
        end else if (!full) begin
            sum_out   <= sum_nxt[SUM_W-1:0];
            fill      <= fill + FILL_ONE;
            sum_valid <= ((fill + FILL_ONE) == FILL_WIN);
        end else begin
            sum_out   <= sum_nxt[SUM_W-1:0];
            sum_valid <= 1'b1;
        end
    end

`ifdef SLIDING_SUM_OVF_EN
    // Sticky overflow of the pre-subtraction add; a new line clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (en) begin
            if (restart && sol) begin
                ovf <= 1'b0;
            end else if (!restart && add_res[SUM_W]) begin
                ovf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window_sum.sv
// Self-checking bench for sliding_window_sum (WIN=5, DATA_W=13, SUM_W=16).
// With SLIDING_SUM_OVF_EN defined, a second SUM_W=15 instance checks ovf.
module tb_sliding_window_sum;

    typedef struct {
        string       tag;
        logic        rst_n;
        logic        en;
        logic        sol;
        logic [12:0] data;
        logic [15:0] exp_sum;
        logic        exp_valid;
        logic [4:0]  exp_fill;
    } vec_t;

    typedef struct {
        string       tag;
        logic [15:0] sum;
        logic        valid;
        logic [4:0]  fill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sol;
    logic [12:0] data_in;
    logic [15:0] sum_out;
    logic        sum_valid;
    logic [4:0]  fill;

    int passed;
    int total;

    vec_t tbl[$];
    exp_t exp_q[$];

`ifdef SLIDING_SUM_OVF_EN
    logic        ovf_main;
    logic        ovf_15;
    logic [14:0] sum_15;
    logic        valid_15;
    logic [4:0]  fill_15;
`endif

    sliding_window_sum #(
        .DATA_W (13),
        .SUM_W  (16),
        .WIN    (5),
        .PTR_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sol       (sol),
        .data_in   (data_in),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .fill      (fill)
`ifdef SLIDING_SUM_OVF_EN
        ,
        .ovf       (ovf_main)
`endif
    );

`ifdef SLIDING_SUM_OVF_EN
    sliding_window_sum #(
        .DATA_W (13),
        .SUM_W  (15),
        .WIN    (5),
        .PTR_W  (4)
    ) u_ovf (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sol       (sol),
        .data_in   (data_in),
        .sum_out   (sum_15),
        .sum_valid (valid_15),
        .fill      (fill_15),
        .ovf       (ovf_15)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d passed=%0d", total, passed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string tag, input logic r, input logic e, input logic s,
                                input int d, input int sum, input logic v, input int f);
        vec_t x;
        x.tag       = tag;
        x.rst_n     = r;
        x.en        = e;
        x.sol       = s;
        x.data      = 13'(d);
        x.exp_sum   = 16'(sum);
        x.exp_valid = v;
        x.exp_fill  = 5'(f);
        return x;
    endfunction

    // Drive one cycle, queue its expectation, then compare just after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        rst_n   = v.rst_n;
        en      = v.en;
        sol     = v.sol;
        data_in = v.data;
        exp_q.push_back('{v.tag, v.exp_sum, v.exp_valid, v.exp_fill});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({v.tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".sum"},   32'(sum_out),   32'(e.sum));
            check({e.tag, ".valid"}, 32'(sum_valid), 32'(e.valid));
            check({e.tag, ".fill"},  32'(fill),      32'(e.fill));
        end
    endtask

    initial begin
        int ramp_sum [10] = '{1, 3, 6, 10, 15, 20, 25, 30, 35, 40};
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        sol     = 1'b0;
        data_in = '0;

        // Reset and idle: everything zero, sol ignored while en is low.
        tbl.push_back(mk("reset0", 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("reset1", 0, 1, 1, 77, 0, 0, 0));
        tbl.push_back(mk("idle_sol", 1, 0, 1, 55, 0, 0, 0));

        // Ramp 1..10 with sol on the first sample.
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk($sformatf("ramp%0d", i + 1), 1, 1, (i == 0), i + 1,
                             ramp_sum[i], (i >= 4), (i >= 4) ? 5 : i + 1));
        end

        // Same ramp with a 3-cycle en gap between samples 6 and 7.
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk($sformatf("gap_s%0d", i + 1), 1, 1, (i == 0), i + 1,
                             ramp_sum[i], (i >= 4), (i >= 4) ? 5 : i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk($sformatf("gap_idle%0d", i), 1, 0, (i == 1), 999, 20, 0, 5));
        end
        tbl.push_back(mk("gap_s7", 1, 1, 0, 7, 25, 1, 5));

        // Mid-line sol on a full window, then constant 7.
        tbl.push_back(mk("msol0", 1, 1, 1, 7, 7, 0, 1));
        tbl.push_back(mk("msol1", 1, 1, 0, 7, 14, 0, 2));
        tbl.push_back(mk("msol2", 1, 1, 0, 7, 21, 0, 3));
        tbl.push_back(mk("msol3", 1, 1, 0, 7, 28, 0, 4));
        tbl.push_back(mk("msol4", 1, 1, 0, 7, 35, 1, 5));
        tbl.push_back(mk("msol5", 1, 1, 0, 7, 35, 1, 5));

        // Reset after sample 3; next plain sample restarts the window.
        tbl.push_back(mk("rmid1", 1, 1, 1, 2, 2, 0, 1));
        tbl.push_back(mk("rmid2", 1, 1, 0, 3, 5, 0, 2));
        tbl.push_back(mk("rmid3", 1, 1, 0, 4, 9, 0, 3));
        tbl.push_back(mk("rmid_rst", 0, 1, 0, 100, 0, 0, 0));
        tbl.push_back(mk("rmid_after", 1, 1, 0, 9, 9, 0, 1));

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Steady state at full scale; pointer walks 0..4 repeatedly.
        for (int k = 1; k <= 20; k++) begin
            int n;
            n = (k < 5) ? k : 5;
            apply(mk($sformatf("steady%0d", k), 1, 1, (k == 1), 8191, n * 8191, (k >= 5), n));
            check($sformatf("steady%0d.wptr", k), 32'(dut.u_buf.wptr), 32'(k % 5));
        end

`ifdef SLIDING_SUM_OVF_EN
        // Five full-scale samples overflow a 15-bit sum on the fifth add.
        for (int k = 1; k <= 6; k++) begin
            int n;
            n = (k < 5) ? k : 5;
            apply(mk($sformatf("ovf%0d", k), 1, 1, (k == 1), 8191, n * 8191, (k >= 5), n));
            check($sformatf("ovf%0d.flag15", k), 32'(ovf_15), (k >= 5) ? 32'd1 : 32'd0);
            check($sformatf("ovf%0d.flag16", k), 32'(ovf_main), 32'd0);
        end
        apply(mk("ovf_clear", 1, 1, 1, 1, 1, 0, 1));
        check("ovf_clear.flag15", 32'(ovf_15), 32'd0);
`endif

        en  = 1'b0;
        sol = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
